// File: rtl/bsg_xnor_rr_sched.sv
// Round-robin scheduler that shares one XNOR/equality datapath among els_p
// requesters and holds the result in a one-entry output register.
module bsg_xnor_rr_sched #(
  parameter int unsigned width_p = 64,
  parameter int unsigned els_p   = 4,
  localparam int unsigned lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   a_i,
  input  logic [els_p*width_p-1:0]   b_i,
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic                       eq_o,
  output logic [lg_els_lp-1:0]       id_o,
  input  logic                       yumi_i
);

  logic [width_p-1:0]   a_arr [els_p];
  logic [width_p-1:0]   b_arr [els_p];

  logic                 v_q;
  logic [width_p-1:0]   data_q;
  logic                 eq_q;
  logic [lg_els_lp-1:0] id_q;
  logic [lg_els_lp-1:0] ptr_q;
  logic [lg_els_lp-1:0] ptr_d;

  logic                 ready_c;
  logic                 found_c;
  logic                 grant_c;
  logic [lg_els_lp-1:0] gidx_c;
  logic [width_p-1:0]   xnor_c;
  logic [els_p-1:0]     onehot_c;
  int unsigned          idx_v;

  for (genvar k = 0; k < els_p; k++) begin : g_unpack
    assign a_arr[k] = a_i[k*width_p +: width_p];
    assign b_arr[k] = b_i[k*width_p +: width_p];
  end

  assign ready_c = ~v_q | yumi_i;

  // First valid requester at or above ptr_q, wrapping past els_p-1.
  always_comb begin
    found_c  = 1'b0;
    gidx_c   = '0;
    idx_v    = 0;
    onehot_c = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      idx_v = 32'(ptr_q) + i;
      if (idx_v >= els_p) idx_v = idx_v - els_p;
      if (!found_c && v_i[lg_els_lp'(idx_v)]) begin
        found_c = 1'b1;
        gidx_c  = lg_els_lp'(idx_v);
      end
    end
    onehot_c[gidx_c] = 1'b1;
  end

  // No grant while reset is asserted, so no operands are consumed then.
  assign grant_c = found_c & ready_c & ~reset_i;
  assign yumi_o  = grant_c ? onehot_c : '0;

  assign xnor_c = ~(a_arr[gidx_c] ^ b_arr[gidx_c]);
  assign ptr_d  = (32'(gidx_c) == els_p - 1) ? '0 : lg_els_lp'(32'(gidx_c) + 1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      eq_q   <= 1'b0;
      id_q   <= '0;
      ptr_q  <= '0;
    end else if (grant_c) begin
      v_q    <= 1'b1;
      data_q <= xnor_c;
      eq_q   <= &xnor_c;
      id_q   <= gidx_c;
      ptr_q  <= ptr_d;
    end else if (yumi_i) begin
      v_q    <= 1'b0;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign eq_o   = eq_q;
  assign id_o   = id_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_q)) else $error("yumi_i asserted with no valid result");
      assert ($onehot0(yumi_o)) else $error("yumi_o is not one-hot or zero");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_xnor_rr_sched.sv
// Self-checking bench for bsg_xnor_rr_sched: directed table, hand sequences
// and randomized traffic against a queue-free behavioural model.
module tb_bsg_xnor_rr_sched;
  localparam int W = 64;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] a_i, b_i;
  logic [N-1:0]   yumi_o;
  logic           v_o, eq_o, yumi_i, yumi_want;
  logic [W-1:0]   data_o;
  logic [1:0]     id_o;

  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model state
  int           m_ptr, m_id, last_g;
  logic         m_v, m_eq;
  logic [W-1:0] m_data;

  // samples from the most recent step
  logic [N-1:0] s_yumi;
  logic         s_vo;
  logic [1:0]   s_id;

  typedef struct {
    logic [N-1:0] v;
    logic         yw;
    logic [N-1:0] exp_yumi;
    logic         exp_vo;
    int           exp_id;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  assign yumi_i = yumi_want & v_o;

  bsg_xnor_rr_sched #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .a_i(a_i), .b_i(b_i),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .eq_o(eq_o), .id_o(id_o),
    .yumi_i(yumi_i)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_i[k*W +: W] = a;
    b_i[k*W +: W] = b;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_v = 1'b0; m_data = '0; m_eq = 1'b0; m_id = 0; last_g = -1;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int g, idx;
    logic yi;
    logic [N-1:0] exp_y;
    logic [W-1:0] x;
    #1;
    yi = yumi_i;
    g = -1;
    x = '0;
    if (!m_v || yi) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v_i[idx]) g = idx;
      end
    end
    exp_y = (g >= 0) ? N'(1 << g) : '0;
    s_yumi = yumi_o;
    chk("yumi_o", W'(yumi_o), W'(exp_y));
    if (g >= 0) x = ~(a_i[g*W +: W] ^ b_i[g*W +: W]);
    @(posedge clk);
    if (g >= 0) begin
      m_v = 1'b1; m_data = x; m_eq = (x == '1); m_id = g; m_ptr = (g + 1) % N;
    end else if (yi) begin
      m_v = 1'b0;
    end
    last_g = g;
    #1;
    s_vo = v_o;
    s_id = id_o;
    chk("v_o", W'(v_o), W'(m_v));
    if (m_v) begin
      chk("data_o", data_o, m_data);
      chk("eq_o", W'(eq_o), W'(m_eq));
      chk("id_o", W'(id_o), W'(m_id));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; v_i = '1; a_i = '0; b_i = '0; yumi_want = 1'b0;
    model_reset();
    #3;
    chk("reset yumi_o", W'(yumi_o), '0);
    chk("reset v_o", W'(v_o), '0);
    chk("reset data_o", data_o, '0);
    chk("reset eq_o", W'(eq_o), '0);
    chk("reset id_o", W'(id_o), '0);
    @(negedge clk);
    v_i = '0;
    reset_i = 1'b0;

    // single request
    set_req(2, 64'hFFFF0000_12345678, 64'h0000FFFF_12345678);
    v_i = 4'b0100; yumi_want = 1'b1;
    step();
    chk("single yumi", W'(s_yumi), W'(4'b0100));
    chk("single data", data_o, 64'h00000000_FFFFFFFF);
    chk("single id", W'(id_o), 64'd2);
    chk("single eq", W'(eq_o), 64'd0);
    v_i = '0;
    step();

    // equality flag
    set_req(1, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);
    v_i = 4'b0010;
    step();
    chk("eq data", data_o, '1);
    chk("eq flag", W'(eq_o), 64'd1);
    chk("eq id", W'(id_o), 64'd1);
    v_i = '0;
    step();

    // round-robin, backpressure, skip/wrap, then park a result from id 3
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, {$urandom, $urandom}, {$urandom, $urandom});
    tbl = '{
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 0}, '{4'b1111, 1'b1, 4'b0010, 1'b1, 1},
      '{4'b1111, 1'b1, 4'b0100, 1'b1, 2}, '{4'b1111, 1'b1, 4'b1000, 1'b1, 3},
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 0}, '{4'b1111, 1'b1, 4'b0010, 1'b1, 1},
      '{4'b1111, 1'b0, 4'b0000, 1'b1, 1}, '{4'b1111, 1'b0, 4'b0000, 1'b1, 1},
      '{4'b1111, 1'b0, 4'b0000, 1'b1, 1}, '{4'b1111, 1'b0, 4'b0000, 1'b1, 1},
      '{4'b1111, 1'b0, 4'b0000, 1'b1, 1}, '{4'b1111, 1'b1, 4'b0100, 1'b1, 2},
      '{4'b0011, 1'b1, 4'b0001, 1'b1, 0}, '{4'b0011, 1'b1, 4'b0010, 1'b1, 1},
      '{4'b0011, 1'b1, 4'b0001, 1'b1, 0}, '{4'b0001, 1'b1, 4'b0001, 1'b1, 0},
      '{4'b1000, 1'b1, 4'b1000, 1'b1, 3}, '{4'b0000, 1'b0, 4'b0000, 1'b1, 3}
    };
    foreach (tbl[i]) begin
      v_i = tbl[i].v; yumi_want = tbl[i].yw;
      step();
      chk($sformatf("tbl%0d yumi", i), W'(s_yumi), W'(tbl[i].exp_yumi));
      chk($sformatf("tbl%0d v_o", i), W'(s_vo), W'(tbl[i].exp_vo));
      chk($sformatf("tbl%0d id", i), W'(s_id), W'(tbl[i].exp_id));
    end

    // async reset pulse between edges while holding id 3
    v_i = 4'b1010;
    #2 reset_i = 1'b1;
    #1;
    chk("async v_o", W'(v_o), '0);
    chk("async data_o", data_o, '0);
    chk("async eq_o", W'(eq_o), '0);
    chk("async id_o", W'(id_o), '0);
    chk("async yumi_o", W'(yumi_o), '0);
    v_i = '0;
    #1 reset_i = 1'b0;
    model_reset();
    @(negedge clk);
    v_i = 4'b1010; yumi_want = 1'b1;
    step();
    chk("post-reset grant", W'(s_yumi), W'(4'b0010));
    chk("post-reset id", W'(s_id), 64'd1);

    // randomized traffic; operands change only when idle or just granted
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!v_i[k] || last_g == k) begin
          logic [W-1:0] ra;
          ra = {$urandom, $urandom};
          v_i[k] = ($urandom_range(0, 2) != 0);
          set_req(k, ra, ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom});
        end else if ($urandom_range(0, 9) == 0) begin
          v_i[k] = 1'b0;
        end
      end
      yumi_want = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
